// File: rtl/spi_ram_master_ctrl_if.sv
// Host-side request/response bundle for the SPI-RAM master controller.
interface spi_ram_master_ctrl_if #(
    parameter int MEM_WIDTH = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [MEM_WIDTH-1:0] req_addr;
    logic [MEM_WIDTH-1:0] req_wdata;
    logic                 rsp_valid;
    logic [MEM_WIDTH-1:0] rsp_rdata;
    logic                 busy;

    // Host agent side
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    // Controller side
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/spi_ram_master_ctrl.sv
// SPI-RAM master: turns one host write/read request into the slave's two
// frames (address, then data) and returns a one-cycle completion strobe.
module spi_ram_master_ctrl #(
    parameter int MEM_WIDTH = 8,
    parameter int RD_GAP    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_ram_master_ctrl_if.slave  host,
    output logic                  SS_n,
    output logic                  MOSI,
    input  logic                  MISO
);
    // One SPI word is the 2-bit command followed by the payload.
    localparam int FW = MEM_WIDTH + 2;
    localparam logic [3:0] SHIFT_LAST = 4'(FW - 1);
    localparam logic [3:0] CAP_LAST   = 4'(MEM_WIDTH - 1);
    localparam logic [3:0] GAP_LAST   = 4'(RD_GAP - 1);

    typedef enum logic [2:0] {IDLE, SEL, SHIFT, RD_WAIT, RD_CAP, END} state_t;

    state_t               state_q, state_d;
    logic                 frame_q, frame_d;   // 0 = address frame, 1 = data frame
    logic                 wr_q, wr_d;
    logic [MEM_WIDTH-1:0] addr_q, addr_d;
    logic [MEM_WIDTH-1:0] wdata_q, wdata_d;
    logic [FW-1:0]        sh_q, sh_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [MEM_WIDTH-2:0] cap_q, cap_d;       // top bit lives only in cap_full
    logic                 ss_n_q, ss_n_d;
    logic                 mosi_q, mosi_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [MEM_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0]           cmd;
    logic [FW-1:0]        word;
    logic [MEM_WIDTH-1:0] cap_full;

    // Frame word for the current frame; cmd[1] selects read, cmd[0] the data frame.
    always_comb begin
        cmd      = {~wr_q, frame_q};
        word     = {cmd, (frame_q ? (wr_q ? wdata_q : '0) : addr_q)};
        cap_full = {cap_q, MISO};
    end

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        ss_n_d      = ss_n_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (host.req_valid) begin
                    wr_d    = host.req_write;
                    addr_d  = host.req_addr;
                    wdata_d = host.req_wdata;
                    frame_d = 1'b0;
                    ss_n_d  = 1'b0;
                    mosi_d  = ~host.req_write;
                    state_d = SEL;
                end
            end
            SEL: begin
                // The slave samples cmd[1] here, then sees the whole word.
                mosi_d  = word[FW-1];
                sh_d    = {word[FW-2:0], 1'b0};
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    cnt_d  = '0;
                    mosi_d = 1'b0;
                    if (frame_q && !wr_q) begin
                        state_d = (RD_GAP == 0) ? RD_CAP : RD_WAIT;
                    end else begin
                        ss_n_d      = 1'b1;
                        rsp_valid_d = frame_q;
                        state_d     = END;
                    end
                end else begin
                    mosi_d = sh_q[FW-1];
                    sh_d   = {sh_q[FW-2:0], 1'b0};
                    cnt_d  = cnt_q + 4'd1;
                end
            end
            RD_WAIT: begin
                // Give the slave/RAM time to present read data on MISO.
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = RD_CAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RD_CAP: begin
                cap_d = cap_full[MEM_WIDTH-2:0];
                if (cnt_q == CAP_LAST) begin
                    ss_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = cap_full;
                    state_d     = END;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            END: begin
                if (!frame_q) begin
                    frame_d = 1'b1;
                    ss_n_d  = 1'b0;
                    mosi_d  = ~wr_q;
                    state_d = SEL;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                ss_n_d  = 1'b1;
                mosi_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the transaction and releases SS_n.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign SS_n           = ss_n_q;
    assign MOSI           = mosi_q;
    assign host.req_ready = (state_q == IDLE);
    assign host.busy      = (state_q != IDLE);
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// Bench for spi_ram_master_ctrl: two builds (RD_GAP=2 and RD_GAP=0), expected
// frames/responses queued by the stimulus and checked by a negedge monitor.
module tb_spi_ram_master_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_ram_master_ctrl_if #(.MEM_WIDTH(W)) h0 ();
    spi_ram_master_ctrl_if #(.MEM_WIDTH(W)) h1 ();

    logic [1:0] ssn, mosi, miso;

    spi_ram_master_ctrl #(.MEM_WIDTH(W), .RD_GAP(2)) u_dut0 (
        .clk(clk), .rst(rst), .host(h0), .SS_n(ssn[0]), .MOSI(mosi[0]), .MISO(miso[0]));
    spi_ram_master_ctrl #(.MEM_WIDTH(W), .RD_GAP(0)) u_dut1 (
        .clk(clk), .rst(rst), .host(h1), .SS_n(ssn[1]), .MOSI(mosi[1]), .MISO(miso[1]));

    logic [1:0]   rv, acc;
    logic [W-1:0] rd [2];
    assign rv[0]  = h0.rsp_valid;
    assign rv[1]  = h1.rsp_valid;
    assign acc[0] = h0.req_valid && h0.req_ready;
    assign acc[1] = h1.req_valid && h1.req_ready;
    assign rd[0]  = h0.rsp_rdata;
    assign rd[1]  = h1.rsp_rdata;

    typedef struct { int dut; logic [10:0] bits; int start; } frm_t;
    typedef struct { int dut; logic [7:0] rdata; int lat; } rsp_t;
    frm_t fq[$];
    rsp_t rq[$];

    int tests = 0;
    int fails = 0;

    // Slave model read words, per DUT
    logic [7:0] sw [2];

    // Per-DUT monitor state
    int          k  [2];
    int          nb [2];
    int          st [2];
    logic [10:0] bits [2];
    bit          prv [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            k[d] = 0; nb[d] = 0; st[d] = 0; bits[d] = '0; prv[d] = 0; sw[d] = '0;
        end
        miso = 2'b11;
    end

    // Monitor + slave MISO model: k counts cycles since the last acceptance.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int cst;
            frm_t f;
            rsp_t r;
            cst = (d == 0) ? 26 : 24;
            if (acc[d]) k[d] = 0; else k[d] = k[d] + 1;
            if (k[d] >= cst && k[d] < cst + 8) miso[d] = sw[d][7 - (k[d] - cst)];
            else                               miso[d] = 1'b1;

            if (rst || ssn[d]) begin
                nb[d] = 0;
            end else if (nb[d] < 11) begin
                if (nb[d] == 0) st[d] = k[d];
                bits[d] = {bits[d][9:0], mosi[d]};
                nb[d]   = nb[d] + 1;
                if (nb[d] == 11) begin
                    tests++;
                    if (fq.size() == 0 || fq[0].dut != d) begin
                        fails++;
                        $display("FAIL frame_unexpected dut%0d: got %h at cycle %0d, none expected",
                                 d, bits[d], st[d]);
                    end else begin
                        f = fq.pop_front();
                        if (bits[d] !== f.bits || st[d] != f.start) begin
                            fails++;
                            $display("FAIL frame dut%0d: got %h start %0d, expected %h start %0d",
                                     d, bits[d], st[d], f.bits, f.start);
                        end
                    end
                end
            end

            if (rv[d]) begin
                tests++;
                if (prv[d]) begin
                    fails++;
                    $display("FAIL rsp_valid_width dut%0d: got 2 consecutive cycles, expected 1", d);
                end else if (rq.size() == 0 || rq[0].dut != d) begin
                    fails++;
                    $display("FAIL rsp_unexpected dut%0d: got rsp_valid at cycle %0d, none expected", d, k[d]);
                end else begin
                    r = rq.pop_front();
                    if (rd[d] !== r.rdata || k[d] != r.lat) begin
                        fails++;
                        $display("FAIL rsp dut%0d: got rdata %h at cycle %0d, expected %h at cycle %0d",
                                 d, rd[d], k[d], r.rdata, r.lat);
                    end
                end
            end
            prv[d] = rv[d];
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] fw(logic [1:0] cmd, logic [7:0] p);
        return {cmd[1], cmd, p};
    endfunction

    // Queue both frames and the response of one request.
    task automatic push_txn(int d, bit wr, logic [7:0] a, logic [7:0] wd, int lat, logic [7:0] rdx);
        frm_t f;
        rsp_t r;
        f.dut = d; f.start = 1;  f.bits = fw(wr ? 2'b00 : 2'b10, a);
        fq.push_back(f);
        f.dut = d; f.start = 13; f.bits = fw(wr ? 2'b01 : 2'b11, wr ? wd : 8'h00);
        fq.push_back(f);
        r.dut = d; r.rdata = rdx; r.lat = lat;
        rq.push_back(r);
    endtask

    task automatic set_req(int d, bit v, bit wr, logic [7:0] a, logic [7:0] wd);
        if (d == 0) begin
            h0.req_valid = v; h0.req_write = wr; h0.req_addr = a; h0.req_wdata = wd;
        end else begin
            h1.req_valid = v; h1.req_write = wr; h1.req_addr = a; h1.req_wdata = wd;
        end
    endtask

    // Present a request and hold it until accepted; n = edges taken. Leaves valid high.
    task automatic issue(int d, bit wr, logic [7:0] a, logic [7:0] wd, output int n);
        bit r, ok;
        set_req(d, 1'b1, wr, a, wd);
        n = 0; ok = 0;
        while (!ok && n < 200) begin
            r = (d == 0) ? h0.req_ready : h1.req_ready;
            @(posedge clk); #1;
            n++;
            ok = r;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL accept_timeout dut%0d: got no acceptance in %0d cycles, expected one", d, n);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((fq.size() != 0 || rq.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (fq.size() != 0 || rq.size() != 0) begin
            fails++;
            $display("FAIL done_timeout: got %0d frames/%0d rsps outstanding, expected 0",
                     fq.size(), rq.size());
            fq.delete();
            rq.delete();
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int n, n2;
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_ss_n", ssn[0], 1);
        chk("rst_mosi", mosi[0], 0);
        chk("rst_rsp_valid", rv[0], 0);
        chk("rst_rsp_rdata", rd[0], 0);
        chk("rst_req_ready", h0.req_ready, 1);
        chk("rst_busy", h0.busy, 0);

        // Write 0x3C <- 0xA5
        push_txn(0, 1, 8'h3C, 8'hA5, 24, 8'h00);
        issue(0, 1, 8'h3C, 8'hA5, n);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("wr_busy_c1", h0.busy, 1);
        chk("wr_ready_c1", h0.req_ready, 0);
        wait_done();

        // Read 0x81, slave returns 0x5A
        sw[0] = 8'h5A;
        push_txn(0, 0, 8'h81, 8'h00, 34, 8'h5A);
        issue(0, 0, 8'h81, 8'h00, n);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_done();

        // Back-to-back write then read with req_valid held high
        sw[0] = 8'h96;
        push_txn(0, 1, 8'h10, 8'hFF, 24, 8'h5A);
        push_txn(0, 0, 8'h10, 8'h00, 34, 8'h96);
        issue(0, 1, 8'h10, 8'hFF, n);
        issue(0, 0, 8'h10, 8'h00, n2);
        chk("b2b_accept_cycle", n2, 25);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_done();

        // Request presented while busy must be ignored
        push_txn(0, 1, 8'h55, 8'h0F, 24, 8'h96);
        issue(0, 1, 8'h55, 8'h0F, n);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (4) begin @(posedge clk); #1; end
        set_req(0, 1'b1, 1'b0, 8'hAA, 8'hBB);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_done();

        // Reset in the middle of a write's first SHIFT
        issue(0, 1, 8'h3C, 8'hA5, n);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst_ss_n", ssn[0], 1);
        chk("midrst_mosi", mosi[0], 0);
        chk("midrst_rdata", rd[0], 0);
        chk("midrst_busy", h0.busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_ready", h0.req_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("postrst_ss_n", ssn[0], 1);
            chk("postrst_rsp_valid", rv[0], 0);
        end

        // Write after reset: rsp_rdata must still read cleared value
        push_txn(0, 1, 8'h01, 8'h02, 24, 8'h00);
        issue(0, 1, 8'h01, 8'h02, n);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_done();

        // RD_GAP=0 build: read 0x00, slave returns 0xC3
        sw[1] = 8'hC3;
        push_txn(1, 0, 8'h00, 8'h00, 32, 8'hC3);
        issue(1, 0, 8'h00, 8'h00, n);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_done();

        repeat (40) begin @(posedge clk); #1; end
        chk("final_ss_n0", ssn[0], 1);
        chk("final_ss_n1", ssn[1], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_ram_master_ctrl.md
# spi_ram_master_ctrl

Host-side transaction sequencer for the SPI-RAM slave. It accepts one write or read request at a time from a parallel host interface. Each request is broken into the two SPI frames the slave expects: address then data for writes, read-address then read-data for reads. The controller drives SS_n and MOSI bit-serially, captures the MEM_WIDTH-bit read word from MISO, and returns it on a single-cycle response strobe. It sits between the host/testbench agent and the SPI slave + RAM pair.

## Interface
- MEM_WIDTH, 8, payload width of every frame; an SPI word is MEM_WIDTH+2 bits.
- RD_GAP, 2, cycles SS_n is held low after the read-data frame before MISO capture starts (covers slave/RAM tx_valid latency); legal range 0..15.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  host request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_write  in  1  1 = write, 0 = read; latched at acceptance.
- req_addr  in  MEM_WIDTH  RAM address; latched at acceptance.
- req_wdata  in  MEM_WIDTH  write data; latched at acceptance, ignored for reads.
- rsp_valid  out  1  one-cycle completion strobe for both writes and reads.
- rsp_rdata  out  MEM_WIDTH  read word; updated only on read completion, held otherwise.
- busy  out  1  state != IDLE.
- SS_n  out  1  slave select, active low, registered.
- MOSI  out  1  serial data to slave, registered.
- MISO  in  1  serial data from slave.

## Operation
- Reset state: IDLE. SS_n=1, MOSI=0, rsp_valid=0, rsp_rdata=0, req_ready=1, busy=0.
- Acceptance happens at a rising edge where req_valid && req_ready. The write flag, address and data are latched at that edge. req_valid at any other time is ignored.
- Command codes (cmd[1:0]): 00 write-address, 01 write-data, 10 read-address, 11 read-data.
  - A write request sends frame 00/addr, then frame 01/wdata.
  - A read request sends frame 10/addr, then frame 11/0.
- FSM states: IDLE, SEL, SHIFT, RD_WAIT, RD_CAP, END.
- IDLE: goes to SEL on acceptance with frame index 0.
- SEL: SS_n=0, MOSI=cmd[1], 1 cycle. This is the bit the slave uses in CHK_CMD to choose write or read. Goes to SHIFT.
- SHIFT: SS_n=0. MOSI sends {cmd[1:0], payload} MSB first, MEM_WIDTH+2 cycles counted by a 4-bit bit counter. Exit depends on the frame:
  - read-data frame goes to RD_WAIT, or straight to RD_CAP if RD_GAP=0;
  - any other frame goes to END.
- RD_WAIT: SS_n=0, MOSI=0, RD_GAP cycles, then RD_CAP.
- RD_CAP: SS_n=0, MOSI=0, MEM_WIDTH cycles. Each edge shifts MISO into a capture register MSB first, giving capture = {capture[MEM_WIDTH-2:0], MISO}. Then END.
- END: SS_n=1, MOSI=0, 1 cycle.
  - After frame 0, the frame index becomes 1 and the FSM goes to SEL.
  - After frame 1, rsp_valid=1 for this cycle and the FSM returns to IDLE.
  - For a read, rsp_rdata is loaded from the capture register on the edge entering END, so it is valid together with rsp_valid.
- Reset mid-operation:
  - SS_n goes to 1 and MOSI to 0 immediately (asynchronously); the FSM goes to IDLE.
  - The partial transaction is discarded and no rsp_valid is produced.
  - rsp_rdata clears to 0.

## Timing
- Cycle numbering: cycle 0 ends with the acceptance edge; cycle k is the k-th cycle after it.
- Write:
  - frame 0: SEL at cycle 1, SHIFT at cycles 2-11, END at cycle 12;
  - frame 1: SEL at 13, SHIFT at 14-23, END at 24 with rsp_valid=1;
  - req_ready=1 again at cycle 25.
- Read (RD_GAP=2):
  - frame 0: cycles 1-12 as for write;
  - frame 1: SEL at 13, SHIFT at 14-23, RD_WAIT at 24-25, RD_CAP at 26-33 (MISO sampled at the end of each);
  - END at 34 with rsp_valid=1 and rsp_rdata valid.
- General read latency: 34 + (RD_GAP-2) cycles.
- SS_n is high for exactly 1 cycle between the two frames of a request.
- Back-to-back requests: req_valid held high is accepted at the edge ending the first IDLE cycle, so SS_n is high for at least 2 cycles between requests.
- rsp_valid is never high for more than 1 consecutive cycle.

## Test plan
- Reset value check: assert rst mid-SHIFT at cycle 7 of a write, deassert, then idle for 5 cycles -> SS_n=1 immediately and throughout, rsp_valid never asserted, req_ready=1 after release.
- Write request: addr=0x3C, wdata=0xA5.
  - MOSI serial trace is 0, 0,0,0011_1100, then (after SS_n high at cycle 12) 0, 0,1,1010_0101.
  - rsp_valid at cycle 24 only.
- Read request: addr=0x81, with a slave model driving MISO=0x5A bits MSB first during cycles 26-33.
  - Frames carry 1,1,0,1000_0001, then 1,1,1,0000_0000.
  - rsp_valid at cycle 34 with rsp_rdata=0x5A.
- Back-to-back: write(0x10,0xFF) immediately followed by read(0x10) with req_valid held high.
  - Second acceptance at the edge ending cycle 25.
  - SS_n high for 2 cycles between the requests.
  - Read returns the slave model value.
- Request while busy: pulse req_valid with different fields during cycle 5 of a write -> request ignored, the original frames are unchanged, exactly 1 rsp_valid.
- RD_GAP=0 build: read(0x00) with MISO=0xC3 -> RD_CAP at cycles 24-31, rsp_valid at 32, rsp_rdata=0xC3.
